// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state codes, instruction codes and the 1149.1 transition function.
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_EX2DR = 4'h0,
        ST_EX1DR = 4'h1,
        ST_SHDR  = 4'h2,
        ST_PAUDR = 4'h3,
        ST_SELIR = 4'h4,
        ST_UPDDR = 4'h5,
        ST_CAPDR = 4'h6,
        ST_SELDR = 4'h7,
        ST_EX2IR = 4'h8,
        ST_EX1IR = 4'h9,
        ST_SHIR  = 4'hA,
        ST_PAUIR = 4'hB,
        ST_RTI   = 4'hC,
        ST_UPDIR = 4'hD,
        ST_CAPIR = 4'hE,
        ST_TLR   = 4'hF
    } tap_state_t;

    localparam int unsigned INSTR_IDCODE    = 1;
    localparam int unsigned INSTR_USER_BASE = 2;

    // BYPASS is the all-ones code for whatever IR width is in use.
    function automatic int unsigned instr_bypass(input int unsigned ir_width);
        return (1 << ir_width) - 1;
    endfunction

    function automatic tap_state_t next_state(input tap_state_t cur, input logic tms);
        tap_state_t nxt;
        nxt = ST_TLR;
        case (cur)
            ST_TLR:   nxt = tms ? ST_TLR   : ST_RTI;
            ST_RTI:   nxt = tms ? ST_SELDR : ST_RTI;
            ST_SELDR: nxt = tms ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: nxt = tms ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  nxt = tms ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: nxt = tms ? ST_UPDDR : ST_PAUDR;
            ST_PAUDR: nxt = tms ? ST_EX2DR : ST_PAUDR;
            ST_EX2DR: nxt = tms ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: nxt = tms ? ST_SELDR : ST_RTI;
            ST_SELIR: nxt = tms ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: nxt = tms ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  nxt = tms ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: nxt = tms ? ST_UPDIR : ST_PAUIR;
            ST_PAUIR: nxt = tms ? ST_EX2IR : ST_PAUIR;
            ST_EX2IR: nxt = tms ? ST_UPDIR : ST_SHIR;
            ST_UPDIR: nxt = tms ? ST_SELDR : ST_RTI;
            default:  nxt = ST_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register plus one-hot decodes of the states that carry actions.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       tms,
    output tap_state_t state,
    output logic       cap_ir,
    output logic       sh_ir,
    output logic       upd_ir,
    output logic       cap_dr,
    output logic       sh_dr,
    output logic       upd_dr,
    output logic       tlr
);

    tap_state_t state_reg;

    // Advance the TAP state on every TCK edge; reset forces Test-Logic-Reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_TLR;
        end else begin
            state_reg <= next_state(state_reg, tms);
        end
    end

    assign state  = state_reg;
    assign cap_ir = (state_reg == ST_CAPIR);
    assign sh_ir  = (state_reg == ST_SHIR);
    assign upd_ir = (state_reg == ST_UPDIR);
    assign cap_dr = (state_reg == ST_CAPDR);
    assign sh_dr  = (state_reg == ST_SHDR);
    assign upd_dr = (state_reg == ST_UPDDR);
    assign tlr    = (state_reg == ST_TLR);

endmodule

// File: rtl/jtag_tap.sv
// TAP controller top: instruction register, IDCODE/BYPASS/user chains and the TDO mux.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter int          N_USER     = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                         TCK,
    input  logic                         TRST,
    input  logic                         TMS,
    input  logic                         TDI,
    output logic                         TDO,
    output logic                         TDO_EN,
    output logic [3:0]                   state,
    output logic [IR_WIDTH-1:0]          ir,
    input  logic [N_USER*DR_WIDTH-1:0]   dr_in,
    output logic [N_USER*DR_WIDTH-1:0]   dr_out,
    output logic [N_USER-1:0]            dr_upd,
    output logic [N_USER-1:0]            dr_cap
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
    localparam int unsigned         BYP_CODE  = instr_bypass(IR_WIDTH);

    tap_state_t fsm_state;
    logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, tlr;

    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_sr_reg;
    logic [31:0]         id_sr_reg;
    logic [DR_WIDTH-1:0] usr_sr_reg;
    logic                byp_reg;

    logic                sel_id;
    logic [N_USER-1:0]   sel_user;
    logic                sel_usr_any;
    logic [DR_WIDTH-1:0] usr_cap;
    logic [DR_WIDTH:0]   usr_ext;
    logic                tdo_sel;

    jtag_tap_fsm u_fsm (
        .clk    (TCK),
        .srst   (TRST),
        .tms    (TMS),
        .state  (fsm_state),
        .cap_ir (cap_ir),
        .sh_ir  (sh_ir),
        .upd_ir (upd_ir),
        .cap_dr (cap_dr),
        .sh_dr  (sh_dr),
        .upd_dr (upd_dr),
        .tlr    (tlr)
    );

    // Instruction decode; a user code that would alias BYPASS or overflow the IR never selects a chain.
    assign sel_id = (ir_reg == IR_IDCODE);

    generate
        for (genvar gi = 0; gi < N_USER; gi++) begin : g_sel
            localparam int unsigned CODE = INSTR_USER_BASE + gi;
            localparam bit          FITS = (CODE < BYP_CODE);
            assign sel_user[gi] = FITS && (ir_reg == IR_WIDTH'(CODE));
        end
    endgenerate

    assign sel_usr_any = |sel_user;

    // Pick the capture value of the selected user chain; all chains share one shift register.
    always_comb begin
        usr_cap = '0;
        for (int k = 0; k < N_USER; k++) begin
            if (sel_user[k]) begin
                usr_cap = dr_in[k*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    // Right shift with TDI into the MSB, written so that a 1-bit chain also works.
    assign usr_ext = {TDI, usr_sr_reg};

    // Instruction path: capture 01, shift, update; TLR restores IDCODE.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_reg    <= IR_IDCODE;
            ir_sr_reg <= '0;
        end else begin
            if (cap_ir) begin
                ir_sr_reg <= IR_WIDTH'(1);
            end else if (sh_ir) begin
                ir_sr_reg <= {TDI, ir_sr_reg[IR_WIDTH-1:1]};
            end
            if (upd_ir) begin
                ir_reg <= ir_sr_reg;
            end else if (tlr) begin
                ir_reg <= IR_IDCODE;
            end
        end
    end

    // Data shift registers: capture or shift only the register the instruction selects.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            id_sr_reg  <= '0;
            usr_sr_reg <= '0;
            byp_reg    <= 1'b0;
        end else if (cap_dr) begin
            if (sel_id) begin
                id_sr_reg <= IDCODE_VAL;
            end else if (sel_usr_any) begin
                usr_sr_reg <= usr_cap;
            end else begin
                byp_reg <= 1'b0;
            end
        end else if (sh_dr) begin
            if (sel_id) begin
                id_sr_reg <= {TDI, id_sr_reg[31:1]};
            end else if (sel_usr_any) begin
                usr_sr_reg <= usr_ext[DR_WIDTH:1];
            end else begin
                byp_reg <= TDI;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_USER; gi++) begin : g_chain
            logic [DR_WIDTH-1:0] out_reg;
            logic                upd_reg;
            logic                cap_reg;

            // Per-chain update register with its registered update/capture pulses.
            always_ff @(posedge TCK) begin
                if (TRST) begin
                    out_reg <= '0;
                    upd_reg <= 1'b0;
                    cap_reg <= 1'b0;
                end else begin
                    upd_reg <= upd_dr && sel_user[gi];
                    cap_reg <= cap_dr && sel_user[gi];
                    if (upd_dr && sel_user[gi]) begin
                        out_reg <= usr_sr_reg;
                    end
                end
            end

            assign dr_out[gi*DR_WIDTH +: DR_WIDTH] = out_reg;
            assign dr_upd[gi] = upd_reg;
            assign dr_cap[gi] = cap_reg;
        end
    endgenerate

    // TDO is the LSB of whichever register is shifting, and 0 outside the shift states.
    always_comb begin
        tdo_sel = 1'b0;
        if (sh_ir) begin
            tdo_sel = ir_sr_reg[0];
        end else if (sh_dr) begin
            if (sel_id) begin
                tdo_sel = id_sr_reg[0];
            end else if (sel_usr_any) begin
                tdo_sel = usr_sr_reg[0];
            end else begin
                tdo_sel = byp_reg;
            end
        end
    end

    assign TDO    = tdo_sel;
    assign TDO_EN = sh_ir | sh_dr;
    assign state  = fsm_state;
    assign ir     = ir_reg;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: reset, IR load, user chains, pause/resume, BYPASS, IDCODE, TRST mid-shift.
module tb_jtag_tap;

    localparam int IRW = 4;
    localparam int DRW = 8;
    localparam int NU  = 2;

    logic              TCK = 1'b0;
    logic              TRST;
    logic              TMS;
    logic              TDI;
    logic              TDO;
    logic              TDO_EN;
    logic [3:0]        state;
    logic [IRW-1:0]    ir;
    logic [NU*DRW-1:0] dr_in;
    logic [NU*DRW-1:0] dr_out;
    logic [NU-1:0]     dr_upd;
    logic [NU-1:0]     dr_cap;

    int n_checks = 0;
    int n_err    = 0;
    int cap_cnt  = 0;
    int upd_cnt  = 0;

    always #5 TCK = ~TCK;

    jtag_tap #(
        .IR_WIDTH   (IRW),
        .DR_WIDTH   (DRW),
        .N_USER     (NU),
        .IDCODE_VAL (32'h1000_0001)
    ) dut (
        .TCK    (TCK),
        .TRST   (TRST),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .TDO_EN (TDO_EN),
        .state  (state),
        .ir     (ir),
        .dr_in  (dr_in),
        .dr_out (dr_out),
        .dr_upd (dr_upd),
        .dr_cap (dr_cap)
    );

    // Count cycles in which any capture or update pulse is high.
    always @(negedge TCK) begin
        if (|dr_cap) cap_cnt++;
        if (|dr_upd) upd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    // Shift n bits LSB-first, recording TDO before each edge; optionally leave Shift on the last bit.
    task automatic shift(input logic [31:0] din, input int n, input logic do_exit, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            step(do_exit && (i == n - 1), din[i]);
        end
    endtask

    // From RTI: load an instruction and return to RTI.
    task automatic load_ir(input logic [IRW-1:0] code, output logic [31:0] dout);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift(32'(code), IRW, 1'b1, dout);
        step(1, 0); step(0, 0);
    endtask

    // From RTI or UpdDR-bound idle: SelDR, CapDR, ShDR.
    task automatic to_shdr();
        step(1, 0); step(0, 0); step(0, 0);
    endtask

    // From Exit1-DR: UpdDR, then RTI with the update visible.
    task automatic finish_dr();
        step(1, 0); step(0, 0);
    endtask

    initial begin
        logic [31:0] d;
        TRST  = 1'b1;
        TMS   = 1'b0;
        TDI   = 1'b0;
        dr_in = {8'hA5, 8'h5A};

        // Reset
        step(0, 0); step(0, 0);
        chk("reset_state", 32'(state), 32'hF);
        chk("reset_ir", 32'(ir), 32'h1);
        chk("reset_tdo", {30'd0, TDO_EN, TDO}, 32'h0);
        chk("reset_dr_out", 32'(dr_out), 32'h0);
        chk("reset_pulses", {28'd0, dr_upd, dr_cap}, 32'h0);
        TRST = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_state", 32'(state), 32'hF);
        chk("tlr_ir", 32'(ir), 32'h1);
        step(0, 0);
        chk("rti_state", 32'(state), 32'hC);

        // IR load of USER0
        load_ir(4'h2, d);
        chk("ir_capture_tdo", d, 32'h1);
        chk("ir_user0", 32'(ir), 32'h2);

        // USER0 capture/shift/update
        cap_cnt = 0;
        to_shdr();
        chk("shdr_state", 32'(state), 32'h2);
        chk("shdr_tdo_en", 32'(TDO_EN), 32'h1);
        chk("user0_cap_pulse", 32'(dr_cap), 32'h1);
        shift(32'h81, 8, 1'b1, d);
        chk("user0_tdo", d, 32'h5A);
        chk("user0_cap_once", 32'(cap_cnt), 32'd1);
        upd_cnt = 0;
        finish_dr();
        chk("user0_out", 32'(dr_out[7:0]), 32'h81);
        chk("user0_upd", 32'(dr_upd), 32'h1);
        chk("user1_hold", 32'(dr_out[15:8]), 32'h0);
        step(0, 0);
        chk("user0_upd_end", 32'(dr_upd), 32'h0);
        chk("user0_upd_once", 32'(upd_cnt), 32'd1);

        // Split shift through Pause/Exit2
        to_shdr();
        shift(32'h81, 8, 1'b1, d);
        chk("split_tdo1", d, 32'h5A);
        step(0, 0); step(0, 0); step(0, 0); step(0, 0);
        chk("pause_state", 32'(state), 32'h3);
        chk("pause_tdo", {30'd0, TDO_EN, TDO}, 32'h0);
        cap_cnt = 0;
        step(1, 0); step(0, 0);
        chk("resume_state", 32'(state), 32'h2);
        shift(32'h55, 8, 1'b1, d);
        chk("resume_tdo", d, 32'h81);
        chk("resume_no_cap", 32'(cap_cnt), 32'd0);
        finish_dr();
        chk("split_out", 32'(dr_out[7:0]), 32'h55);

        // USER1
        load_ir(4'h3, d);
        chk("ir_user1", 32'(ir), 32'h3);
        to_shdr();
        chk("user1_cap_pulse", 32'(dr_cap), 32'h2);
        shift(32'h3C, 8, 1'b1, d);
        chk("user1_tdo", d, 32'hA5);
        finish_dr();
        chk("user1_out", 32'(dr_out), 32'h3C55);
        chk("user1_upd", 32'(dr_upd), 32'h2);

        // BYPASS (all ones) and an undefined code
        load_ir(4'hF, d);
        chk("ir_bypass", 32'(ir), 32'hF);
        cap_cnt = 0;
        upd_cnt = 0;
        to_shdr();
        shift(32'b1101, 4, 1'b1, d);
        chk("bypass_tdo", d, 32'b1010);
        finish_dr();
        chk("bypass_no_upd", 32'(dr_upd), 32'h0);
        chk("bypass_dr_out", 32'(dr_out), 32'h3C55);
        load_ir(4'h7, d);
        chk("ir_undef", 32'(ir), 32'h7);
        to_shdr();
        shift(32'b1101, 4, 1'b1, d);
        chk("undef_tdo", d, 32'b1010);
        finish_dr();
        step(0, 0);
        chk("undef_dr_out", 32'(dr_out), 32'h3C55);
        chk("bypass_no_pulses", 32'(cap_cnt + upd_cnt), 32'd0);

        // IDCODE after TLR, then TRST mid-shift
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_ir_restore", 32'(ir), 32'h1);
        step(0, 0);
        to_shdr();
        shift(32'h0, 32, 1'b0, d);
        chk("idcode_tdo", d, 32'h1000_0001);
        chk("idcode_still_shift", 32'(state), 32'h2);
        step(0, 1);
        upd_cnt = 0;
        TRST = 1'b1;
        step(0, 0);
        TRST = 1'b0;
        chk("trst_state", 32'(state), 32'hF);
        chk("trst_tdo", {30'd0, TDO_EN, TDO}, 32'h0);
        chk("trst_dr_out", 32'(dr_out), 32'h0);
        step(1, 0);
        chk("trst_no_upd", 32'(upd_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
